// File: rtl/nbit_demux_1x2_reg_pkg.sv
// Shared project header for the 1x2 registered demux.
// Holds the port-select encoding and the per-slot state type used by the slices.
package nbit_demux_1x2_reg_pkg;

    // Destination encoding carried on in_sel
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // One-entry slot occupancy; a slot presents valid exactly when FULL
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // True when the given select value addresses port A
    function automatic logic selects_a(input logic sel);
        return (sel == SEL_A);
    endfunction

endpackage : nbit_demux_1x2_reg_pkg

// File: rtl/nbit_reg_slice.sv
// One-entry N-bit register slice with valid/ready handshake on both sides
// and a wrapping counter of completed output transfers.
module nbit_reg_slice
    import nbit_demux_1x2_reg_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    slot_state_t   state_q;
    slot_state_t   state_d;
    logic [N-1:0]  data_q;
    logic [N-1:0]  data_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          capture;
    logic          drain;

    // Handshake decode: accept when empty, or when full and draining this cycle
    always_comb begin
        in_ready = 1'b0;
        capture  = 1'b0;
        drain    = 1'b0;
        in_ready = (state_q == SLOT_EMPTY) || out_ready;
        capture  = in_valid && in_ready;
        drain    = (state_q == SLOT_FULL) && out_ready;
    end

    // Next-state logic: fill on capture, empty on drain without capture, refill on both
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (capture) begin
                    state_d = SLOT_FULL;
                    data_d  = in_data;
                end
            end
            SLOT_FULL: begin
                if (capture) begin
                    state_d = SLOT_FULL;
                    data_d  = in_data;
                end else if (drain) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase
        if (drain) begin
            count_d = count_q + CW'(1);
        end
    end

    // State, held word and transfer counter; reset discards any held word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Outputs come straight from the registers so the sink sees a clean interface
    always_comb begin
        out_valid = (state_q == SLOT_FULL);
        out_data  = data_q;
        count     = count_q;
    end

endmodule : nbit_reg_slice

// File: rtl/nbit_demux_1x2_reg.sv
// 1x2 registered demux: steers a valid/ready source stream to port A or B
// according to in_sel, each port buffered by its own one-entry register slice.
module nbit_demux_1x2_reg
    import nbit_demux_1x2_reg_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    input  logic          in_sel,
    output logic          in_ready,
    output logic [N-1:0]  a_data,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [N-1:0]  b_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count
);

    logic a_in_valid;
    logic b_in_valid;
    logic a_in_ready;
    logic b_in_ready;

    // Steering: only the selected slice sees in_valid, and in_ready reflects only that slice
    always_comb begin
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        in_ready   = 1'b0;
        if (selects_a(in_sel)) begin
            a_in_valid = in_valid;
            in_ready   = a_in_ready;
        end else begin
            b_in_valid = in_valid;
            in_ready   = b_in_ready;
        end
    end

    nbit_reg_slice #(
        .N  (N),
        .CW (CW)
    ) u_slice_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_data),
        .out_valid (a_valid),
        .out_ready (a_ready),
        .count     (a_count)
    );

    nbit_reg_slice #(
        .N  (N),
        .CW (CW)
    ) u_slice_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_data),
        .out_valid (b_valid),
        .out_ready (b_ready),
        .count     (b_count)
    );

endmodule : nbit_demux_1x2_reg

// File: tb/tb_nbit_demux_1x2_reg.sv
// Directed self-checking bench for nbit_demux_1x2_reg (N=8, CW=8).
module tb_nbit_demux_1x2_reg;

    logic       clk;
    logic       rst;
    logic [7:0] inData;
    logic       inValid;
    logic       inSel;
    logic       inReady;
    logic [7:0] aData;
    logic       aValid;
    logic       aReady;
    logic [7:0] bData;
    logic       bValid;
    logic       bReady;
    logic [7:0] aCount;
    logic [7:0] bCount;

    int checks   = 0;
    int failures = 0;
    int expB     = 0;
    int expA     = 0;

    nbit_demux_1x2_reg #(
        .N  (8),
        .CW (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (inData),
        .in_valid (inValid),
        .in_sel   (inSel),
        .in_ready (inReady),
        .a_data   (aData),
        .a_valid  (aValid),
        .a_ready  (aReady),
        .b_data   (bData),
        .b_valid  (bValid),
        .b_ready  (bReady),
        .a_count  (aCount),
        .b_count  (bCount)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all source and sink inputs in one go
    task automatic applyStimulus(input logic sel, input logic [7:0] data, input logic valid,
                                 input logic aRdy, input logic bRdy);
        inSel   = sel;
        inData  = data;
        inValid = valid;
        aReady  = aRdy;
        bReady  = bRdy;
    endtask

    // One comparison: count it, and on mismatch count the failure and report
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #3;
        checkOutput("rst_a_valid", {31'd0, aValid}, 32'd0);
        checkOutput("rst_b_valid", {31'd0, bValid}, 32'd0);
        checkOutput("rst_a_data", {24'd0, aData}, 32'h00);
        checkOutput("rst_b_data", {24'd0, bData}, 32'h00);
        checkOutput("rst_a_count", {24'd0, aCount}, 32'd0);
        checkOutput("rst_b_count", {24'd0, bCount}, 32'd0);
        #9;
        rst = 1'b1;

        // Single word to A, drained immediately
        applyStimulus(1'b0, 8'h5A, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("first_in_ready", {31'd0, inReady}, 32'd1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("first_a_valid", {31'd0, aValid}, 32'd1);
        checkOutput("first_a_data", {24'd0, aData}, 32'h5A);
        checkOutput("first_b_valid", {31'd0, bValid}, 32'd0);
        checkOutput("first_a_count0", {24'd0, aCount}, 32'd0);
        tick();
        checkOutput("first_a_count1", {24'd0, aCount}, 32'd1);
        checkOutput("first_a_empty", {31'd0, aValid}, 32'd0);
        checkOutput("first_a_hold", {24'd0, aData}, 32'h5A);

        // A stalled holding 0x11; 0x22 to A is refused, 0x33 to B accepted
        applyStimulus(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("fill_a_ready", {31'd0, inReady}, 32'd1);
        tick();
        applyStimulus(1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("stall_a_ready", {31'd0, inReady}, 32'd0);
        tick();
        checkOutput("stall_a_data", {24'd0, aData}, 32'h11);
        checkOutput("stall_b_untouched", {31'd0, bValid}, 32'd0);
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("b_ready_indep", {31'd0, inReady}, 32'd1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("b_data_33", {24'd0, bData}, 32'h33);
        checkOutput("b_valid_33", {31'd0, bValid}, 32'd1);
        checkOutput("a_still_11", {24'd0, aData}, 32'h11);

        // B full and stalled must not block a word aimed at A once A frees up
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        expA = 2;
        checkOutput("a_count_after_11", {24'd0, aCount}, expA);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("a_ready_b_full", {31'd0, inReady}, 32'd1);

        // Drain 0x33 from B
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        expB = 1;
        checkOutput("b_drain_count", {24'd0, bCount}, expB);
        checkOutput("b_drain_valid", {31'd0, bValid}, 32'd0);

        // Stream 0x01..0x10 to B at one word per cycle
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
            #1;
            checkOutput($sformatf("stream_ready_%0d", i), {31'd0, inReady}, 32'd1);
            tick();
            checkOutput($sformatf("stream_data_%0d", i), {24'd0, bData}, i);
            checkOutput($sformatf("stream_valid_%0d", i), {31'd0, bValid}, 32'd1);
            checkOutput($sformatf("stream_count_%0d", i), {24'd0, bCount}, expB + i - 1);
        end
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        expB = expB + 16;
        checkOutput("stream_count_final", {24'd0, bCount}, expB);
        checkOutput("stream_empty", {31'd0, bValid}, 32'd0);

        // A full with 0x44, drain and refill with 0x55 in the same cycle
        applyStimulus(1'b0, 8'h44, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("a_data_44", {24'd0, aData}, 32'h44);
        applyStimulus(1'b0, 8'h55, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("refill_ready", {31'd0, inReady}, 32'd1);
        tick();
        expA = expA + 1;
        checkOutput("refill_data", {24'd0, aData}, 32'h55);
        checkOutput("refill_valid", {31'd0, aValid}, 32'd1);
        checkOutput("refill_count", {24'd0, aCount}, expA);

        // Push A's counter up to 255 then one more transfer wraps it to 0
        for (int j = 0; j < 252; j++) begin
            applyStimulus(1'b0, 8'(j), 1'b1, 1'b1, 1'b0);
            tick();
        end
        expA = expA + 252;
        checkOutput("count_at_255", {24'd0, aCount}, 32'd255);
        checkOutput("count_at_255_model", {24'd0, aCount}, expA);
        checkOutput("last_stream_a", {24'd0, aData}, 32'hFB);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("count_wrap", {24'd0, aCount}, 32'd0);

        // Fill both slots, then pulse reset between edges
        applyStimulus(1'b0, 8'h66, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("both_full_a", {31'd0, aValid}, 32'd1);
        checkOutput("both_full_b", {31'd0, bValid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_a_valid", {31'd0, aValid}, 32'd0);
        checkOutput("mid_rst_b_valid", {31'd0, bValid}, 32'd0);
        checkOutput("mid_rst_a_data", {24'd0, aData}, 32'h00);
        checkOutput("mid_rst_b_data", {24'd0, bData}, 32'h00);
        checkOutput("mid_rst_a_count", {24'd0, aCount}, 32'd0);
        checkOutput("mid_rst_b_count", {24'd0, bCount}, 32'd0);
        #2;
        rst = 1'b1;

        // First word after reset release behaves like the very first word
        applyStimulus(1'b0, 8'h5A, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("post_rst_ready", {31'd0, inReady}, 32'd1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("post_rst_a_valid", {31'd0, aValid}, 32'd1);
        checkOutput("post_rst_a_data", {24'd0, aData}, 32'h5A);
        checkOutput("post_rst_b_valid", {31'd0, bValid}, 32'd0);
        checkOutput("post_rst_count0", {24'd0, aCount}, 32'd0);
        tick();
        checkOutput("post_rst_count1", {24'd0, aCount}, 32'd1);
        checkOutput("post_rst_b_count", {24'd0, bCount}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nbit_demux_1x2_reg

// File: doc/nbit_demux_1x2_reg.md
NBIT_DEMUX_1X2_REG -- requirements
Module: nbit_demux_1x2_reg

Interface
REQ-001 Parameter N, default 8: data width in bits.
REQ-002 Parameter CW, default 8: width of each per-port transfer counter.
REQ-003 The reset behaviour SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 in_data  input  N  source word.
REQ-007 in_valid  input  1  source word present.
REQ-008 in_sel  input  1  destination: 0 = port A, 1 = port B.
REQ-009 in_ready  output  1  source word accepted this cycle when in_valid=1.
REQ-010 a_data  output  N  port A word (registered).
REQ-011 a_valid  output  1  port A word present.
REQ-012 a_ready  input  1  port A sink accepts.
REQ-013 b_data  output  N  port B word (registered).
REQ-014 b_valid  output  1  port B word present.
REQ-015 b_ready  input  1  port B sink accepts.
REQ-016 a_count  output  CW  completed port A transfers, wrapping.
REQ-017 b_count  output  CW  completed port B transfers, wrapping.

Function
REQ-018 Each port SHALL hold a one-entry slot with states EMPTY and FULL; x_valid=1 exactly when the slot is FULL.
REQ-019 A source transfer SHALL occur when in_valid=1 and in_ready=1; a port transfer SHALL occur when x_valid=1 and x_ready=1.
REQ-020 in_ready SHALL be combinational: 1 when the slot selected by in_sel is EMPTY, or FULL with its x_ready=1 in the same cycle.
REQ-021 in_ready SHALL NOT depend on the state of the unselected port.
REQ-022 On a source transfer the selected slot SHALL capture in_data at the next edge; latency in_valid to x_valid is exactly 1 cycle.
REQ-023 Slot transitions: EMPTY->FULL on capture; FULL->EMPTY on drain without capture; FULL->FULL with new data on simultaneous drain and capture; otherwise hold.
REQ-024 x_data SHALL remain stable while x_valid=1 and x_ready=0.
REQ-025 The unselected slot SHALL never capture, regardless of in_valid.
REQ-026 Sustained in_valid=1 with x_ready=1 SHALL give one word per cycle on the selected port.
REQ-027 a_count/b_count SHALL increment by 1 on each port transfer and wrap from 2^CW-1 to 0.
REQ-028 Words SHALL leave each port in the order they were accepted for that port; no word is duplicated or dropped.
REQ-029 x_data while x_valid=0 is don't-care to the sink but SHALL be the last captured value (0 after reset).

Reset
REQ-030 While rst=0: a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0, both slots EMPTY, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard held words; no transfer SHALL be counted in the cycle reset deasserts.
REQ-032 in_ready SHALL follow REQ-020 from the reset state (1 after reset when in_valid targets an empty slot).

Structure
REQ-033 Constants SEL_A=0 and SEL_B=1 SHALL live in the shared project header, not in this module.
REQ-034 One sub-module, nbit_reg_slice (one-entry N-bit slot with valid/ready and transfer counter), SHALL be instantiated twice.
REQ-035 The demux logic SHALL be only in_sel steering of valid/ready; no clocked state outside the slices.

Verification
REQ-036 N=8: reset, in_sel=0, in_data=0x5A, in_valid=1 one cycle, a_ready=1 -> next cycle a_valid=1, a_data=0x5A, b_valid=0; a_count=1 the cycle after.
REQ-037 Port A stalled (a_ready=0, slot FULL 0x11); send 0x22 to A then 0x33 to B -> in_ready=0 for A, then 1 for B; b_data=0x33 next cycle; a_data stays 0x11.
REQ-038 Streaming 0x01..0x10 to B with b_ready=1 -> 16 words, in order, one per cycle, b_count=16, in_ready constantly 1.
REQ-039 Slot A FULL 0x44, a_ready=1 and in_sel=0 in_data=0x55 same cycle -> in_ready=1, a_data=0x55 next cycle, a_valid stays 1, a_count +1.
REQ-040 CW=8, a_count=255 then one A transfer -> a_count=0.
REQ-041 Both slots FULL, rst pulsed low mid-cycle -> a_valid, b_valid, counts, data 0 immediately; post-release first word behaves as REQ-036.
